// File: rtl/reservation_station.sv
// Reservation station: a compacting queue of renamed instructions that captures CDB results
// and issues the oldest entry whose operands are both ready.
module reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [9:0]                   disp_op,
    input  logic [TAG_W-1:0]             disp_qj,
    input  logic [TAG_W-1:0]             disp_qk,
    input  logic [31:0]                  disp_vj,
    input  logic [31:0]                  disp_vk,
    input  logic [31:0]                  disp_a,
    input  logic                         disp_a_rdy,
    input  logic [TAG_W-1:0]             disp_dest,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_value,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [9:0]                   iss_op,
    output logic [31:0]                  iss_vj,
    output logic [31:0]                  iss_vk,
    output logic [31:0]                  iss_a,
    output logic                         iss_a_rdy,
    output logic [TAG_W-1:0]             iss_dest,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [9:0]       op;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      a;
        logic             a_rdy;
        logic [TAG_W-1:0] dest;
    } entry_t;

    entry_t            slot_q [DEPTH];
    entry_t            slot_d [DEPTH];
    // One extra all-zero entry on top so the shift-down can read index i+1 uniformly.
    entry_t            woke   [DEPTH+1];
    entry_t            disp_e;
    entry_t            sel_e;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  ready_vec;
    logic [IDX_W-1:0]  sel_idx;
    logic              found;
    logic              cdb_hit;
    logic              iss_fire;
    logic              disp_fire;

    assign cdb_hit    = cdb_valid && (cdb_tag != '0);
    assign disp_ready = count_q < CNT_W'(DEPTH);
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_fire   = found && iss_ready;
    assign count      = count_q;

    // Wakeup view of every slot; invalid slots hold all-zero tags and never match.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = slot_q[i];
            if (cdb_hit && slot_q[i].qj == cdb_tag) begin
                woke[i].qj = '0;
                woke[i].vj = cdb_value;
            end
            if (cdb_hit && slot_q[i].qk == cdb_tag) begin
                woke[i].qk = '0;
                woke[i].vk = cdb_value;
            end
        end
        woke[DEPTH] = '0;
    end

    always_comb begin
        disp_e.op    = disp_op;
        disp_e.qj    = disp_qj;
        disp_e.qk    = disp_qk;
        disp_e.vj    = disp_vj;
        disp_e.vk    = disp_vk;
        disp_e.a     = disp_a;
        disp_e.a_rdy = disp_a_rdy;
        disp_e.dest  = disp_dest;
        if (cdb_hit && disp_qj == cdb_tag) begin
            disp_e.qj = '0;
            disp_e.vj = cdb_value;
        end
        if (cdb_hit && disp_qk == cdb_tag) begin
            disp_e.qk = '0;
            disp_e.vk = cdb_value;
        end
    end

    // Oldest-first selection from registered state only.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (CNT_W'(i) < count_q) && (slot_q[i].qj == '0) && (slot_q[i].qk == '0);
            if (ready_vec[i] && !found) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        sel_e = found ? slot_q[sel_idx] : '0;
    end

    assign iss_valid = found;
    assign iss_op    = sel_e.op;
    assign iss_vj    = sel_e.vj;
    assign iss_vk    = sel_e.vk;
    assign iss_a     = sel_e.a;
    assign iss_a_rdy = sel_e.a_rdy;
    assign iss_dest  = sel_e.dest;

    always_comb begin
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_fire && IDX_W'(i) >= sel_idx) begin
                slot_d[i] = woke[i+1];
            end else begin
                slot_d[i] = woke[i];
            end
        end
        if (iss_fire) begin
            count_d = count_q - CNT_W'(1);
        end
        // New entry lands at the post-compaction tail.
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count_d) begin
                    slot_d[i] = disp_e;
                end
            end
            count_d = count_d + CNT_W'(1);
        end
        if (flush) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized bench for reservation_station: a queue-based reference model predicts each cycle's
// outputs and the issued entries, and a negedge monitor compares them against the DUT.
module tb_reservation_station;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [9:0]       op;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      a;
        logic             a_rdy;
        logic [TAG_W-1:0] dest;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             disp_valid = 1'b0;
    logic             disp_ready;
    ent_t             din = '0;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0]      cdb_value = '0;
    logic             iss_valid;
    logic             iss_ready = 1'b0;
    logic [9:0]       iss_op;
    logic [31:0]      iss_vj, iss_vk, iss_a;
    logic             iss_a_rdy;
    logic [TAG_W-1:0] iss_dest;
    logic [CNT_W-1:0] count;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_op    (din.op),
        .disp_qj    (din.qj),
        .disp_qk    (din.qk),
        .disp_vj    (din.vj),
        .disp_vk    (din.vk),
        .disp_a     (din.a),
        .disp_a_rdy (din.a_rdy),
        .disp_dest  (din.dest),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_op     (iss_op),
        .iss_vj     (iss_vj),
        .iss_vk     (iss_vk),
        .iss_a      (iss_a),
        .iss_a_rdy  (iss_a_rdy),
        .iss_dest   (iss_dest),
        .count      (count)
    );

    always #5 clk = ~clk;

    ent_t m_q[$];     // reference contents, oldest first
    ent_t exp_q[$];   // scoreboard of expected issues
    int   exp_count = 0;
    logic exp_ready = 1'b1;
    logic exp_valid = 1'b0;
    ent_t exp_sel   = '0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string pfx, input ent_t e);
        check({pfx, "_op"},    64'(iss_op),    64'(e.op));
        check({pfx, "_vj"},    64'(iss_vj),    64'(e.vj));
        check({pfx, "_vk"},    64'(iss_vk),    64'(e.vk));
        check({pfx, "_a"},     64'(iss_a),     64'(e.a));
        check({pfx, "_a_rdy"}, 64'(iss_a_rdy), 64'(e.a_rdy));
        check({pfx, "_dest"},  64'(iss_dest),  64'(e.dest));
    endtask

    // Monitor: per-cycle state and scoreboard pops on every issue handshake.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            check("count", 64'(count), 64'(exp_count));
            check("disp_ready", 64'(disp_ready), 64'(exp_ready));
            check("iss_valid", 64'(iss_valid), 64'(exp_valid));
            check_out("sel", exp_sel);
            if (iss_valid && iss_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL issue_unexpected: got dest %0h expected no issue at %0t",
                             iss_dest, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_out("issue", e);
                end
            end
        end
    end

    // Drive one cycle of inputs and advance the reference model across the coming edge.
    task automatic step(input logic dv, input ent_t d, input logic cv, input logic [TAG_W-1:0] ct,
                        input logic [31:0] cval, input logic ir, input logic fl);
        int   sel;
        logic full;
        ent_t e;
        @(posedge clk);
        #1;
        disp_valid = dv; din = d; cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
        iss_ready = ir; flush = fl;
        sel = -1;
        foreach (m_q[i]) if (sel < 0 && m_q[i].qj == 0 && m_q[i].qk == 0) sel = i;
        exp_count = m_q.size();
        full      = m_q.size() >= DEPTH;
        exp_ready = !full;
        exp_valid = sel >= 0;
        exp_sel   = (sel >= 0) ? m_q[sel] : '0;
        if (sel >= 0 && ir) exp_q.push_back(m_q[sel]);
        if (fl) begin
            m_q.delete();
        end else begin
            if (sel >= 0 && ir) m_q.delete(sel);
            if (cv && ct != 0) begin
                foreach (m_q[i]) begin
                    if (m_q[i].qj == ct) begin m_q[i].qj = '0; m_q[i].vj = cval; end
                    if (m_q[i].qk == ct) begin m_q[i].qk = '0; m_q[i].vk = cval; end
                end
            end
            if (dv && !full) begin
                e = d;
                if (cv && ct != 0 && d.qj == ct) begin e.qj = '0; e.vj = cval; end
                if (cv && ct != 0 && d.qk == ct) begin e.qk = '0; e.vk = cval; end
                m_q.push_back(e);
            end
        end
    endtask

    function automatic ent_t mk(input int qj, input int qk, input logic [31:0] vj,
                                input logic [31:0] vk, input int dest);
        ent_t e;
        e = '0;
        e.qj = TAG_W'(qj); e.qk = TAG_W'(qk); e.vj = vj; e.vk = vk; e.dest = TAG_W'(dest);
        return e;
    endfunction

    task automatic idle(input logic ir);
        step(1'b0, '0, 1'b0, '0, '0, ir, 1'b0);
    endtask

    function automatic logic [TAG_W-1:0] rtag(input int zero_pct);
        if ($urandom_range(0, 99) < zero_pct) return '0;
        return TAG_W'($urandom_range(1, 7));
    endfunction

    task automatic rand_step(input int rdy_pct, input int disp_pct);
        ent_t d;
        d.op    = 10'($urandom);
        d.qj    = rtag(50);
        d.qk    = rtag(50);
        d.vj    = $urandom;
        d.vk    = $urandom;
        d.a     = $urandom;
        d.a_rdy = 1'($urandom);
        d.dest  = TAG_W'($urandom);
        step(($urandom_range(0, 99) < disp_pct), d, 1'($urandom), rtag(15), $urandom,
             ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 59) == 0));
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_iss_valid", 64'(iss_valid), 64'(0));
        check("rst_disp_ready", 64'(disp_ready), 64'(1));
        check("rst_iss_vj", 64'(iss_vj), 64'(0));
        m_q.delete();
        exp_q.delete();
        exp_count = 0; exp_ready = 1'b1; exp_valid = 1'b0; exp_sel = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        check("reset_count", 64'(count), 64'(0));
        check("reset_disp_ready", 64'(disp_ready), 64'(1));
        check("reset_iss_valid", 64'(iss_valid), 64'(0));
        check_out("reset", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ready dispatch then issue.
        step(1'b1, mk(0, 0, 5, 7, 3), 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        // Wakeup ordering: younger ready B issues before A, then A after the CDB.
        step(1'b1, mk(4, 0, 0, 1, 10), 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, mk(0, 0, 2, 3, 11), 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, '0, 1'b1, TAG_W'(4), 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(1'b1);
        // Dispatch bypass.
        step(1'b1, mk(0, 6, 1, 0, 12), 1'b1, TAG_W'(6), 32'd9, 1'b0, 1'b0);
        idle(1'b1);
        // Fill, overfill attempt, wake slot 2 and issue it, then dispatch + issue together.
        for (int k = 1; k <= 4; k++) step(1'b1, mk(k, 0, 0, k, k + 16), 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, mk(0, 0, 1, 1, 30), 1'b1, TAG_W'(3), 32'h33, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, '0, 1'b1, TAG_W'(1), 32'h11, 1'b0, 1'b0);
        step(1'b1, mk(5, 0, 0, 0, 21), 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1'b0);
        // Flush drops a same-cycle dispatch.
        step(1'b1, mk(0, 0, 9, 9, 9), 1'b0, '0, '0, 1'b0, 1'b1);
        idle(1'b0);

        for (int n = 0; n < 600; n++) rand_step(20, 80);
        for (int n = 0; n < 600; n++) rand_step(70, 50);
        mid_reset();
        for (int n = 0; n < 600; n++) rand_step(45, 60);
        for (int n = 0; n < 5; n++) rand_step(90, 60);
        mid_reset();
        for (int n = 0; n < 600; n++) rand_step(50, 40);
        idle(1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds decoded, renamed instructions between dispatch and one functional unit (ALU, MUL, DIV, LOAD, STORE or BRANCH instance) in the Tomasulo pipeline. Accepts the decoder's operation bundle (Op, Qj/Qk, Vj/Vk, A, A_rdy, Dest) once operand register numbers have been renamed to producer tags. It captures operand values from the common data bus (CDB) and issues the oldest entry whose operands are all ready.

## Interface
- DEPTH, 4: number of entries, 2..16.
- TAG_W, 5: producer tag width; tag 0 is reserved and means "value present".
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (misprediction recovery).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  high when count < DEPTH.
- disp_op  in  10  decoder Op field, {funct3, funct7}.
- disp_qj, disp_qk  in  TAG_W  source producer tags; 0 means the matching V is valid.
- disp_vj, disp_vk  in  32  source values; ignored when the matching Q is nonzero.
- disp_a  in  32  address/immediate field.
- disp_a_rdy  in  1  carried through unchanged.
- disp_dest  in  TAG_W  destination tag.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast producer tag.
- cdb_value  in  32  broadcast value.
- iss_valid  out  1  an entry with qj==0 and qk==0 exists.
- iss_ready  in  1  functional unit accepts.
- iss_op, iss_vj, iss_vk, iss_a, iss_a_rdy, iss_dest  out  10/32/32/32/1/TAG_W  fields of the selected entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a compacting queue. Slot 0 is the oldest entry. Slots 0..count-1 are valid.
- Each slot holds: op, qj, qk, vj, vk, a, a_rdy, dest.
- Dispatch fires when disp_valid && disp_ready. The new entry is written at slot count, after any compaction in the same cycle.
- Dispatch bypass: if cdb_valid and cdb_tag equals a nonzero disp_qj or disp_qk in the same cycle, cdb_value is written into that V and the matching Q is stored as 0.
- Wakeup: every valid slot with qj == cdb_tag != 0 captures vj <= cdb_value and sets qj <= 0. The same applies to qk/vk. Both operands may wake up in the same cycle.
- A broadcast with cdb_tag == 0 is ignored.
- Selection: the lowest-index valid slot with qj==0 and qk==0. The iss_* outputs come combinationally from that slot. When no slot qualifies, the iss_* data outputs are 0.
- Issue fires when iss_valid && iss_ready:
  - the selected slot is removed;
  - slots above it shift down by one, and their wakeup updates from the same cycle apply;
  - count decrements.
- Dispatch and issue in the same cycle leave count unchanged. disp_ready is computed from the registered count only, so there is no same-cycle free-slot bypass when full.
- iss_valid never depends on iss_ready. The selected entry may change between cycles while un-accepted (an older entry can wake up). The functional unit samples only on fire.
- flush: count <= 0 and all slots are invalidated. flush overrides dispatch, issue and wakeup in that cycle.

## Timing
- Reset (asynchronous assert, synchronous release):
  - count=0, disp_ready=1, iss_valid=0;
  - all iss_* data outputs 0;
  - all slot fields 0.
- Dispatch with ready operands at edge N: iss_valid is high in cycle N+1. There is no same-cycle dispatch-to-issue path.
- CDB wakeup at edge N: the entry is eligible from cycle N+1.
- Dispatch bypass at edge N: the entry is eligible from cycle N+1.
- Full: disp_ready=0 while count==DEPTH. An issue at edge N makes disp_ready=1 in cycle N+1.
- Empty: iss_valid=0. A simultaneous dispatch and CDB wakeup into an empty station yields iss_valid=1 in the next cycle.
- rst_n asserted mid-operation discards all entries immediately. No partial state survives.

## Test plan
- Ready dispatch: after reset, dispatch op=10'h000, qj=0, qk=0, vj=5, vk=7, dest=3 at edge 1. Required: cycle 2 shows iss_valid=1, iss_vj=5, iss_vk=7, iss_dest=3. With iss_ready=1, cycle 3 shows count=0 and iss_valid=0.
- Wakeup ordering: dispatch A (qj=4) and then B (ready). Required: B issues first. Then CDB tag 4, value 32'hDEAD_BEEF. Required: next cycle A issues with iss_vj=32'hDEAD_BEEF.
- Dispatch bypass: dispatch qk=6 in the same cycle as CDB tag 6, value 9. Required: the next cycle issues with iss_vk=9.
- Full: fill DEPTH=4 non-ready entries. Required: disp_ready=0 and count=4. Then wake slot 2 and issue it. Required: slot 3 moves to slot 2, count=3, disp_ready=1.
- Simultaneous dispatch and issue at count=2. Required: count stays 2 and the new entry lands in slot 1.
- Flush and reset: with 3 entries valid, pulse flush. Required: count=0 and iss_valid=0 next cycle, and a same-cycle dispatch is dropped. Deassert rst_n mid-stream. Required: outputs return to reset values immediately.
